// File: rtl/issue_ctrl_decode_pkg.sv
// rtl/issue_ctrl_decode_pkg.sv - shared opcodes, ALU-op encodings, control bundle and FSM state
// Contents: package ctrl_pkg (opcode localparams, ALU_OP_* encodings, ctrl_t, state_t).
package ctrl_pkg;

  localparam int CTRL_W = 12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_BR  = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;

  typedef struct packed {
    logic       jump;
    logic       bgtz;
    logic       bne;
    logic       beq;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
  } ctrl_t;

  typedef enum logic {
    ST_PAIR  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

endpackage

// File: rtl/issue_ctrl_decode_if.sv
// rtl/issue_ctrl_decode_if.sv - issue group handshake, pipeline hazard inputs and ID/EX control outputs
// master: upstream/pipeline side (drives in_valid, op_code, rs, rt, rd, stall_in, flush, ex_mem_read, ex_rt)
// slave : decoder side (drives in_ready, out_valid, out_ctrl, out_dest, out_illegal)
interface issue_ctrl_decode_if #(
  parameter int LANES  = 2,
  parameter int REG_AW = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [6*LANES-1:0]       op_code;
  logic [REG_AW*LANES-1:0]  rs;
  logic [REG_AW*LANES-1:0]  rt;
  logic [REG_AW*LANES-1:0]  rd;
  logic                     stall_in;
  logic                     flush;
  logic                     ex_mem_read;
  logic [REG_AW-1:0]        ex_rt;
  logic [LANES-1:0]         out_valid;
  logic [12*LANES-1:0]      out_ctrl;
  logic [REG_AW*LANES-1:0]  out_dest;
  logic [LANES-1:0]         out_illegal;

  modport master (
    output in_valid, op_code, rs, rt, rd, stall_in, flush, ex_mem_read, ex_rt,
    input  in_ready, out_valid, out_ctrl, out_dest, out_illegal
  );

  modport slave (
    input  in_valid, op_code, rs, rt, rd, stall_in, flush, ex_mem_read, ex_rt,
    output in_ready, out_valid, out_ctrl, out_dest, out_illegal
  );
endinterface

// File: rtl/issue_ctrl_decode_lane.sv
// rtl/issue_ctrl_decode_lane.sv - combinational opcode to control bundle decoder for one lane
// Ports: op_code (in, 6) ; ctrl (out, ctrl_t) ; illegal (out) ; reads_rt (out, lane sources rt)
// Build option: CTRL_JUMP_EN makes opcode 000010 decode as a jump instead of illegal.
module ctrl_decode_lane
  import ctrl_pkg::*;
(
  input  logic [5:0] op_code,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       reads_rt
);
  always_comb begin
    ctrl     = '0;
    illegal  = 1'b0;
    reads_rt = 1'b0;
    case (op_code)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_R;
        reads_rt       = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        reads_rt       = 1'b1;
      end
      OP_BEQ: begin
        ctrl.beq    = 1'b1;
        ctrl.alu_op = ALU_OP_BR;
        reads_rt    = 1'b1;
      end
      OP_BNE: begin
        ctrl.bne    = 1'b1;
        ctrl.alu_op = ALU_OP_BR;
        reads_rt    = 1'b1;
      end
      OP_BGTZ: begin
        ctrl.bgtz   = 1'b1;
        ctrl.alu_op = ALU_OP_BR;
      end
`ifdef CTRL_JUMP_EN
      OP_J:    ctrl.jump = 1'b1;
`else
      OP_J:    illegal = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/issue_ctrl_decode.sv
// rtl/issue_ctrl_decode.sv - registered multi-lane ID/EX control decoder with pair split and load-use bubbles
// Ports: clk ; reset (sync, active-high) ; bus (issue_ctrl_decode_if.slave): in_valid/in_ready,
//   op_code/rs/rt/rd per lane, stall_in, flush, ex_mem_read/ex_rt, registered out_valid/out_ctrl/out_dest/out_illegal.
// Build option: CTRL_JUMP_EN (jump decode, handled in ctrl_decode_lane).
module issue_ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int REG_AW = 5
) (
  input  logic               clk,
  input  logic               reset,
  issue_ctrl_decode_if.slave bus
);
  localparam int CW = CTRL_W * LANES;
  localparam int DW = REG_AW * LANES;

  state_t             state;
  logic [LANES-1:0]   out_valid_q, out_illegal_q;
  logic [CW-1:0]      out_ctrl_q;
  logic [DW-1:0]      out_dest_q;
  logic [5:0]         lat_op;
  logic [REG_AW-1:0]  lat_rs, lat_rt, lat_rd;

  logic [CW-1:0]      dec_ctrl_vec;
  logic [DW-1:0]      dec_dest_vec;
  logic [LANES-1:0]   dec_ill, dec_rdrt, dec_mem, dec_wr, lane_lu;
  logic               ex_lu_en, load_use;

  // Split-path signals; tied to zero when LANES == 1.
  logic               split_cond, lat_lu;
  logic [LANES-1:0]   lat_valid_vec, lat_ill_vec;
  logic [CW-1:0]      lat_ctrl_vec;
  logic [DW-1:0]      lat_dest_vec;
  logic [5:0]         l1_op;
  logic [REG_AW-1:0]  l1_rs, l1_rt, l1_rd;

  // Register 0 never carries a loaded value, so it cannot create a load-use hazard.
  assign ex_lu_en = bus.ex_mem_read && (bus.ex_rt != '0);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ctrl_t             c;
    logic [REG_AW-1:0] l_rs, l_rt, l_rd;
    assign l_rs = bus.rs[REG_AW*i +: REG_AW];
    assign l_rt = bus.rt[REG_AW*i +: REG_AW];
    assign l_rd = bus.rd[REG_AW*i +: REG_AW];
    ctrl_decode_lane u_dec (
      .op_code  (bus.op_code[6*i +: 6]),
      .ctrl     (c),
      .illegal  (dec_ill[i]),
      .reads_rt (dec_rdrt[i])
    );
    assign dec_ctrl_vec[CTRL_W*i +: CTRL_W] = c;
    assign dec_dest_vec[REG_AW*i +: REG_AW] = c.reg_dst ? l_rd : l_rt;
    assign dec_mem[i] = c.mem_read | c.mem_write;
    assign dec_wr[i]  = c.reg_write;
    assign lane_lu[i] = ex_lu_en && ((l_rs == bus.ex_rt) || (dec_rdrt[i] && (l_rt == bus.ex_rt)));
  end

  if (LANES == 2) begin : g_split
    ctrl_t             lc;
    logic              l_ill, l_rdrt;
    logic [REG_AW-1:0] d0;
    ctrl_decode_lane u_lat (
      .op_code  (lat_op),
      .ctrl     (lc),
      .illegal  (l_ill),
      .reads_rt (l_rdrt)
    );
    assign d0    = dec_dest_vec[REG_AW-1:0];
    assign l1_op = bus.op_code[11:6];
    assign l1_rs = bus.rs[2*REG_AW-1:REG_AW];
    assign l1_rt = bus.rt[2*REG_AW-1:REG_AW];
    assign l1_rd = bus.rd[2*REG_AW-1:REG_AW];
    // RAW: lane 1 consumes lane 0's result; memory: only one memory port per cycle.
    assign split_cond = (dec_wr[0] && (d0 != '0) && ((d0 == l1_rs) || (dec_rdrt[1] && (d0 == l1_rt))))
                      || (dec_mem[0] && dec_mem[1]);
    assign lat_lu        = ex_lu_en && ((lat_rs == bus.ex_rt) || (l_rdrt && (lat_rt == bus.ex_rt)));
    assign lat_valid_vec = 2'b10;
    assign lat_ill_vec   = {l_ill, 1'b0};
    assign lat_ctrl_vec  = {lc, {CTRL_W{1'b0}}};
    assign lat_dest_vec  = {(lc.reg_dst ? lat_rd : lat_rt), {REG_AW{1'b0}}};
  end else begin : g_single
    assign split_cond    = 1'b0;
    assign lat_lu        = 1'b0;
    assign lat_valid_vec = '0;
    assign lat_ill_vec   = '0;
    assign lat_ctrl_vec  = '0;
    assign lat_dest_vec  = '0;
    assign l1_op         = '0;
    assign l1_rs         = '0;
    assign l1_rt         = '0;
    assign l1_rd         = '0;
  end

  // In SPLIT only the latched lane is about to issue; the waiting group is not examined.
  assign load_use = (state == ST_PAIR) ? (bus.in_valid && (|lane_lu)) : lat_lu;

  assign bus.in_ready = !reset && (state == ST_PAIR) && !bus.stall_in && !bus.flush && !load_use;

  assign bus.out_valid   = out_valid_q;
  assign bus.out_ctrl    = out_ctrl_q;
  assign bus.out_dest    = out_dest_q;
  assign bus.out_illegal = out_illegal_q;

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      state         <= ST_PAIR;
      out_valid_q   <= '0;
      out_ctrl_q    <= '0;
      out_dest_q    <= '0;
      out_illegal_q <= '0;
      lat_op        <= '0;
      lat_rs        <= '0;
      lat_rt        <= '0;
      lat_rd        <= '0;
    end else if (bus.stall_in) begin
      state <= state;
    end else if (load_use || ((state == ST_PAIR) && !bus.in_valid)) begin
      out_valid_q   <= '0;
      out_ctrl_q    <= '0;
      out_dest_q    <= '0;
      out_illegal_q <= '0;
    end else begin
      case (state)
        ST_PAIR: begin
          if (split_cond) begin
            out_valid_q   <= LANES'(1);
            out_ctrl_q    <= CW'(dec_ctrl_vec[CTRL_W-1:0]);
            out_dest_q    <= DW'(dec_dest_vec[REG_AW-1:0]);
            out_illegal_q <= LANES'(dec_ill[0]);
            lat_op        <= l1_op;
            lat_rs        <= l1_rs;
            lat_rt        <= l1_rt;
            lat_rd        <= l1_rd;
            state         <= ST_SPLIT;
          end else begin
            out_valid_q   <= '1;
            out_ctrl_q    <= dec_ctrl_vec;
            out_dest_q    <= dec_dest_vec;
            out_illegal_q <= dec_ill;
          end
        end
        ST_SPLIT: begin
          out_valid_q   <= lat_valid_vec;
          out_ctrl_q    <= lat_ctrl_vec;
          out_dest_q    <= lat_dest_vec;
          out_illegal_q <= lat_ill_vec;
          lat_op        <= '0;
          lat_rs        <= '0;
          lat_rt        <= '0;
          lat_rd        <= '0;
          state         <= ST_PAIR;
        end
        default: state <= ST_PAIR;
      endcase
    end
  end
endmodule

// File: tb/tb_issue_ctrl_decode.sv
// tb/tb_issue_ctrl_decode.sv - self-checking bench for issue_ctrl_decode (LANES=2, REG_AW=5)
module tb_issue_ctrl_decode;
  localparam int LANES = 2;
  localparam int AW    = 5;
`ifdef CTRL_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  issue_ctrl_decode_if #(.LANES(LANES), .REG_AW(AW)) bus ();
  issue_ctrl_decode #(.LANES(LANES), .REG_AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model: instructions waiting to issue after a split, plus expected registered outputs.
  instr_t      held[$];
  logic [1:0]  ev, ei;
  logic [11:0] ec[2];
  logic [4:0]  ed[2];
  logic        exp_rdy;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return '{op: op, rs: rs, rt: rt, rd: rd};
  endfunction

  function automatic logic [11:0] m_ctrl(logic [5:0] op);
    bit r  = (op == 6'b000000);
    bit ad = (op == 6'b001000);
    bit lw = (op == 6'b100011);
    bit sw = (op == 6'b101011);
    bit bq = (op == 6'b000100);
    bit bn = (op == 6'b000101);
    bit bg = (op == 6'b000111);
    bit j  = JUMP_EN && (op == 6'b000010);
    logic [1:0] aop = r ? 2'b10 : ((bq || bn || bg) ? 2'b01 : 2'b00);
    return {j, bg, bn, bq, aop, sw, lw, (r || ad || lw), lw, (ad || lw || sw), r};
  endfunction

  function automatic bit m_legal(logic [5:0] op);
    return op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000111}
           || (JUMP_EN && op == 6'b000010);
  endfunction

  function automatic logic [4:0] m_dest(instr_t i);
    return (i.op == 6'b000000) ? i.rd : i.rt;
  endfunction

  function automatic bit m_reads(instr_t i, logic [4:0] r);
    return (i.rs == r) || ((i.op inside {6'b000000, 6'b101011, 6'b000100, 6'b000101}) && i.rt == r);
  endfunction

  function automatic bit m_lu(instr_t i);
    return bus.ex_mem_read && (bus.ex_rt != 5'd0) && m_reads(i, bus.ex_rt);
  endfunction

  function automatic bit m_writes(logic [5:0] op);
    return op inside {6'b000000, 6'b001000, 6'b100011};
  endfunction

  function automatic bit m_mem(logic [5:0] op);
    return op inside {6'b100011, 6'b101011};
  endfunction

  task automatic bubble();
    ev = '0; ei = '0;
    for (int k = 0; k < 2; k++) begin ec[k] = '0; ed[k] = '0; end
  endtask

  task automatic put(int lane, instr_t i);
    ev[lane] = 1'b1;
    ec[lane] = m_ctrl(i.op);
    ed[lane] = m_dest(i);
    ei[lane] = !m_legal(i.op);
  endtask

  task automatic model_step();
    instr_t l0, l1;
    bit lu;
    l0 = '{op: bus.op_code[5:0],  rs: bus.rs[4:0], rt: bus.rt[4:0], rd: bus.rd[4:0]};
    l1 = '{op: bus.op_code[11:6], rs: bus.rs[9:5], rt: bus.rt[9:5], rd: bus.rd[9:5]};
    exp_rdy = 1'b0;
    if (reset || bus.flush) begin
      bubble();
      held.delete();
    end else if (bus.stall_in) begin
      exp_rdy = 1'b0;
    end else if (held.size() > 0) begin
      if (m_lu(held[0])) bubble();
      else begin
        bubble();
        put(1, held.pop_front());
      end
    end else begin
      lu = bus.in_valid && (m_lu(l0) || m_lu(l1));
      exp_rdy = !lu;
      bubble();
      if (bus.in_valid && !lu) begin
        put(0, l0);
        if ((m_writes(l0.op) && m_dest(l0) != 5'd0 && m_reads(l1, m_dest(l0)))
            || (m_mem(l0.op) && m_mem(l1.op)))
          held.push_back(l1);
        else
          put(1, l1);
      end
    end
  endtask

  task automatic cycle();
    #1;
    model_step();
    chk("in_ready", bus.in_ready, exp_rdy);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid%0d", k),   bus.out_valid[k],          ev[k]);
      chk($sformatf("ctrl%0d", k),    bus.out_ctrl[12*k +: 12],  ec[k]);
      chk($sformatf("dest%0d", k),    bus.out_dest[5*k +: 5],    ed[k]);
      chk($sformatf("illegal%0d", k), bus.out_illegal[k],        ei[k]);
    end
  endtask

  task automatic drive(bit v, instr_t a, instr_t b);
    bus.in_valid = v;
    bus.op_code  = {b.op, a.op};
    bus.rs       = {b.rs, a.rs};
    bus.rt       = {b.rt, a.rt};
    bus.rd       = {b.rd, a.rd};
  endtask

  localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, BGTZ = 6'b000111, J = 6'b000010;

  initial begin
    reset = 1'b1;
    bus.stall_in = 1'b0; bus.flush = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rt = '0;
    bubble();
    drive(1, mk(ADDI, 1, 2, 0), mk(R, 3, 4, 6));
    repeat (3) cycle();
    chk("rst_valid", bus.out_valid, 2'b00);
    chk("rst_ctrl",  bus.out_ctrl,  24'h0);
    chk("rst_ready", bus.in_ready,  1'b0);

    reset = 1'b0;
    cycle();
    chk("pair_valid", bus.out_valid, 2'b11);
    chk("pair_ctrl0", bus.out_ctrl[11:0],  12'h00A);
    chk("pair_ctrl1", bus.out_ctrl[23:12], 12'h089);

    // RAW split
    drive(1, mk(ADDI, 1, 5, 0), mk(R, 5, 4, 7));
    cycle();
    chk("raw_c1_valid", bus.out_valid, 2'b01);
    drive(1, mk(ADDI, 2, 3, 0), mk(ADDI, 4, 6, 0));
    #1 chk("raw_ready_low", bus.in_ready, 1'b0);
    cycle();
    chk("raw_c2_valid", bus.out_valid, 2'b10);
    chk("raw_c2_ctrl1", bus.out_ctrl[23:12], 12'h089);
    chk("raw_c2_dest1", bus.out_dest[9:5], 5'd7);
    cycle();

    // Memory split
    drive(1, mk(LW, 1, 8, 0), mk(SW, 2, 9, 0));
    cycle();
    chk("mem_c1_ctrl0", bus.out_ctrl[11:0], 12'h01E);
    drive(0, mk(R, 0, 0, 0), mk(R, 0, 0, 0));
    cycle();
    chk("mem_sw_ctrl", bus.out_ctrl[23:12], 12'h022);

    // Load-use
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd7;
    drive(1, mk(ADDI, 7, 10, 0), mk(ADDI, 11, 12, 0));
    cycle();
    chk("lu_bubble", bus.out_valid, 2'b00);
    bus.ex_mem_read = 1'b0;
    cycle();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0;
    drive(1, mk(ADDI, 0, 10, 0), mk(ADDI, 11, 12, 0));
    cycle();
    chk("lu_r0_issue", bus.out_valid, 2'b11);
    bus.ex_mem_read = 1'b0;

    // Flush during SPLIT discards latched sw
    drive(1, mk(LW, 1, 8, 0), mk(SW, 2, 9, 0));
    cycle();
    bus.flush = 1'b1;
    cycle();
    chk("flush_bubble", bus.out_valid, 2'b00);
    bus.flush = 1'b0;
    drive(0, mk(R, 0, 0, 0), mk(R, 0, 0, 0));
    cycle();
    drive(1, mk(BEQ, 1, 2, 0), mk(BNE, 3, 4, 0));
    #1 chk("post_flush_ready", bus.in_ready, 1'b1);
    cycle();

    // Stall holds outputs; flush beats stall
    bus.stall_in = 1'b1;
    drive(1, mk(ADDI, 1, 2, 0), mk(ADDI, 3, 4, 0));
    repeat (4) cycle();
    chk("stall_ctrl",  bus.out_ctrl,  24'h240140);
    chk("stall_valid", bus.out_valid, 2'b11);
    bus.flush = 1'b1;
    cycle();
    chk("flush_over_stall", bus.out_valid, 2'b00);
    bus.flush = 1'b0; bus.stall_in = 1'b0;

    // Jump / illegal
    drive(1, mk(J, 0, 0, 0), mk(BGTZ, 5, 0, 0));
    cycle();
    chk("jump_ctrl",  bus.out_ctrl[11:0], JUMP_EN ? 12'h800 : 12'h000);
    chk("jump_ill",   bus.out_illegal[0], !JUMP_EN);
    chk("bgtz_ctrl",  bus.out_ctrl[23:12], 12'h440);
    drive(1, mk(6'b111111, 1, 2, 3), mk(ADDI, 4, 5, 0));
    cycle();
    chk("bad_op_ill", bus.out_illegal, 2'b01);

    // Load-use in SPLIT looks at latched lane only
    drive(1, mk(ADDI, 1, 5, 0), mk(R, 5, 13, 14));
    cycle();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd13;
    drive(1, mk(ADDI, 2, 3, 0), mk(ADDI, 4, 6, 0));
    cycle();
    bus.ex_mem_read = 1'b0;
    cycle();
    chk("split_lu_issue", bus.out_dest[9:5], 5'd14);
    cycle();
    drive(1, mk(LW, 1, 8, 0), mk(SW, 2, 9, 0));
    cycle();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd20;
    drive(1, mk(ADDI, 20, 3, 0), mk(ADDI, 4, 6, 0));
    cycle();
    chk("split_no_lu", bus.out_valid, 2'b10);
    cycle();
    bus.ex_mem_read = 1'b0;
    cycle();

    // Split candidate with load-use: bubble first, then split
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd15;
    drive(1, mk(LW, 1, 3, 0), mk(SW, 4, 15, 0));
    cycle();
    bus.ex_mem_read = 1'b0;
    repeat (2) cycle();

    // Reset mid-SPLIT
    drive(1, mk(LW, 1, 8, 0), mk(SW, 2, 9, 0));
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive(0, mk(R, 0, 0, 0), mk(R, 0, 0, 0));
    cycle();
    chk("rst_split_gone", bus.out_valid, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
